mux8_arbiter: RTL and testbench

- Round-robin arbiter that shares one 8:1 datapath multiplexer among up to 8 requesters.
- Drives the mux select and a one-hot grant vector, and holds each grant until the owner releases it or a hold timeout expires.
- Sits beside the select mux in the processor datapath; the owning requester's data appears on the mux output while Valid=1.

---
 rtl/mux8_arbiter.sv | 125 ++++++++++++
 tb/tb_mux8_arbiter.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux8_arbiter.sv
// mux8_arbiter: round-robin owner select for a shared 8:1 datapath mux, with grant hold timeout.
// Optional grant pinning via a Lock input when MUX8_ARBITER_LOCK_EN is defined.
module mux8_arbiter #(
  parameter int unsigned NUM_REQ  = 8,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 5
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic [7:0] Req,
  input  logic       Done,
`ifdef MUX8_ARBITER_LOCK_EN
  input  logic       Lock,
`endif
  output logic [7:0] Grant,
  output logic [2:0] Sel,
  output logic       Valid,
  output logic       Timeout
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  localparam int unsigned      HOLD_LAST_I = (MAX_HOLD == 0) ? 0 : MAX_HOLD - 1;
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_LAST_I);
  localparam logic [2:0]       LAST_IDX    = 3'(NUM_REQ - 1);
  localparam logic [3:0]       NUM_REQ_4   = 4'(NUM_REQ);
  localparam bit               HOLD_EN     = (MAX_HOLD != 0);

  logic [0:0]       state;
  logic [2:0]       ptr;
  logic [CNT_W-1:0] holdcnt;
  logic [CNT_W-1:0] holdcnt_nxt;
  logic [7:0]       req_m;
  logic             any_req;
  logic [2:0]       winner;
  logic             found;
  logic [3:0]       idx;
  logic             lock;
  logic             hold_full;
  logic             owner_drop;
  logic             release_now;
  logic             timeout_only;
  logic [2:0]       next_ptr;

`ifdef MUX8_ARBITER_LOCK_EN
  assign lock = Lock;
`else
  assign lock = 1'b0;
`endif

  always_comb begin
    req_m = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      req_m[i] = Req[i] && (i < NUM_REQ);
    end
  end

  assign any_req = |req_m;

  // Scan from ptr upward, wrapping at NUM_REQ; the first set masked request wins.
  always_comb begin
    winner = ptr;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = {1'b0, ptr} + 4'(i);
      if (idx >= NUM_REQ_4) begin
        idx = idx - NUM_REQ_4;
      end
      if (!found && req_m[idx[2:0]]) begin
        winner = idx[2:0];
        found  = 1'b1;
      end
    end
  end

  assign hold_full    = HOLD_EN && (holdcnt == HOLD_LAST);
  assign owner_drop   = !req_m[Sel];
  assign release_now  = Done || (!lock && (owner_drop || hold_full));
  assign timeout_only = !lock && hold_full && !Done && !owner_drop;
  assign next_ptr     = (Sel == LAST_IDX) ? 3'd0 : Sel + 3'd1;

  // Under Lock the counter parks at the timeout value so dropping Lock releases immediately.
  always_comb begin
    holdcnt_nxt = holdcnt;
    if (!(lock && hold_full) && (holdcnt != '1)) begin
      holdcnt_nxt = holdcnt + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state   <= IDLE;
      Grant   <= '0;
      Sel     <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      ptr     <= '0;
      holdcnt <= '0;
    end else begin
      Timeout <= 1'b0;
      if (state == IDLE) begin
        if (any_req) begin
          state   <= GRANT;
          Grant   <= 8'h01 << winner;
          Sel     <= winner;
          Valid   <= 1'b1;
          holdcnt <= '0;
        end
      end else begin
        if (release_now) begin
          state   <= IDLE;
          Grant   <= '0;
          Valid   <= 1'b0;
          ptr     <= next_ptr;
          Timeout <= timeout_only;
        end else begin
          holdcnt <= holdcnt_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_mux8_arbiter.sv
// Bench for mux8_arbiter: directed scenarios plus randomized traffic against a cycle-level reference model.
// Instance A: NUM_REQ=8, MAX_HOLD=4. Instance B: NUM_REQ=5, MAX_HOLD=0 (timeout disabled).
module tb_mux8_arbiter;

  localparam int A_N  = 8;
  localparam int A_MH = 4;
  localparam int B_N  = 5;
  localparam int B_MH = 0;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req_a, req_b;
  logic       done_a, done_b, lock_a;
  logic [7:0] grant_a, grant_b;
  logic [2:0] sel_a, sel_b;
  logic       valid_a, valid_b, timeout_a, timeout_b;

  int checks = 0;
  int passes = 0;
  int cyc    = 0;

  // Model state per instance: owner (-1 = none), round-robin start, cycles owned, parked select, timeout pulse.
  int m_owner[2];
  int m_ptr[2];
  int m_age[2];
  int m_sel[2];
  bit m_to[2];

  always #5 clk = ~clk;

  mux8_arbiter #(.NUM_REQ(A_N), .MAX_HOLD(A_MH), .CNT_W(3)) u_dut_a (
    .Clock(clk), .Reset(rst_n), .Req(req_a), .Done(done_a),
`ifdef MUX8_ARBITER_LOCK_EN
    .Lock(lock_a),
`endif
    .Grant(grant_a), .Sel(sel_a), .Valid(valid_a), .Timeout(timeout_a)
  );

  mux8_arbiter #(.NUM_REQ(B_N), .MAX_HOLD(B_MH), .CNT_W(3)) u_dut_b (
    .Clock(clk), .Reset(rst_n), .Req(req_b), .Done(done_b),
`ifdef MUX8_ARBITER_LOCK_EN
    .Lock(1'b0),
`endif
    .Grant(grant_b), .Sel(sel_b), .Valid(valid_b), .Timeout(timeout_b)
  );

  task automatic model_step(input int id, input int n, input int mh, input logic rn,
                            input logic [7:0] req, input logic done, input logic lk);
    bit found;
    bit expired;
    bit drop;
    int j;
    if (!rn) begin
      m_owner[id] = -1; m_ptr[id] = 0; m_age[id] = 0; m_sel[id] = 0; m_to[id] = 0;
    end else begin
      m_to[id] = 0;
      if (m_owner[id] < 0) begin
        found = 0;
        for (int k = 0; k < n; k++) begin
          j = (m_ptr[id] + k) % n;
          if (!found && req[3'(j)]) begin
            found = 1; m_owner[id] = j; m_sel[id] = j; m_age[id] = 1;
          end
        end
      end else begin
        expired = (mh != 0) && (m_age[id] >= mh);
        drop    = !req[3'(m_owner[id])];
        if (done || (!lk && (drop || expired))) begin
          m_to[id]    = !lk && expired && !done && !drop;
          m_ptr[id]   = (m_owner[id] + 1) % n;
          m_owner[id] = -1;
        end else begin
          m_age[id]++;
        end
      end
    end
  endtask

  function automatic logic [12:0] exp_vec(input int id);
    logic [7:0] g;
    g = (m_owner[id] >= 0) ? (8'h01 << m_owner[id]) : 8'h00;
    return {g, 3'(m_sel[id]), (m_owner[id] >= 0), m_to[id]};
  endfunction

  task automatic tick();
    model_step(0, A_N, A_MH, rst_n, req_a, done_a, lock_a);
    model_step(1, B_N, B_MH, rst_n, req_b, done_b, 1'b0);
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_a = '0; req_b = '0; done_a = 1'b0; done_b = 1'b0; lock_a = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_a = 8'hFF; req_b = 8'hFF; done_a = 1'b0; done_b = 1'b0; lock_a = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (grant_a !== 8'h00 || valid_a !== 1'b0 || sel_a !== 3'd0 || timeout_a !== 1'b0)
        $display("FAIL reset_hold c%0d: grant=%h valid=%b sel=%0d to=%b, want 00/0/0/0", c, grant_a, valid_a, sel_a, timeout_a);
      else passes++;
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (grant_a !== 8'h01 || sel_a !== 3'd0 || valid_a !== 1'b1)
      $display("FAIL reset_first_grant_a: grant=%h sel=%0d valid=%b, want 01/0/1", grant_a, sel_a, valid_a);
    else passes++;
    checks++;
    if (grant_b !== 8'h01 || sel_b !== 3'd0 || valid_b !== 1'b1)
      $display("FAIL reset_first_grant_b: grant=%h sel=%0d valid=%b, want 01/0/1", grant_b, sel_b, valid_b);
    else passes++;
    tick();
    rst_n = 1'b0;
    tick();
    checks++;
    if (grant_a !== 8'h00 || valid_a !== 1'b0 || timeout_a !== 1'b0)
      $display("FAIL reset_mid_grant: grant=%h valid=%b to=%b, want 00/0/0", grant_a, valid_a, timeout_a);
    else passes++;
    rst_n = 1'b1; req_a = '0; req_b = '0;
  endtask

  task automatic test_round_robin();
    int seq[$];
    int exp_seq[4] = '{0, 2, 0, 2};
    int age = 0;
    int gap = 0;
    int bad_gap = 0;
    int bad_len = 0;
    do_reset();
    req_a = 8'b0000_0101;
    for (int c = 0; c < 60 && seq.size() < 4; c++) begin
      tick();
      if (valid_a) begin
        if (age == 0) begin
          seq.push_back(int'(sel_a));
          if (seq.size() > 1 && gap != 1) bad_gap++;
          gap = 0;
        end
        age++;
        done_a = (age == 3);
      end else begin
        if (age != 0 && age != 3) bad_len++;
        age = 0; gap++; done_a = 1'b0;
      end
    end
    done_a = 1'b0;
    checks++;
    if (seq.size() != 4) $display("FAIL rr_count: grants seen=%0d, want 4", seq.size());
    else begin
      passes++;
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (seq[i] != exp_seq[i]) $display("FAIL rr_sel%0d: sel=%0d, want %0d", i, seq[i], exp_seq[i]);
        else passes++;
      end
    end
    checks++;
    if (bad_gap != 0 || bad_len != 0)
      $display("FAIL rr_bubble: bad gaps=%0d bad lengths=%0d, want 0/0", bad_gap, bad_len);
    else passes++;
  endtask

  task automatic test_timeout();
    bit ev[6] = '{1, 1, 1, 1, 0, 1};
    bit et[6] = '{0, 0, 0, 0, 1, 0};
    logic [7:0] eg;
    do_reset();
    req_a = 8'h08;
    for (int c = 0; c < 6; c++) begin
      tick();
      eg = ev[c] ? 8'h08 : 8'h00;
      checks++;
      if (valid_a !== ev[c] || timeout_a !== et[c] || sel_a !== 3'd3 || grant_a !== eg)
        $display("FAIL timeout_c%0d: valid=%b to=%b sel=%0d grant=%h, want %b/%b/3/%h", c, valid_a, timeout_a, sel_a, grant_a, ev[c], et[c], eg);
      else passes++;
    end
  endtask

  task automatic test_req_drop();
    do_reset();
    req_a = 8'h20;
    tick();
    tick();
    checks++;
    if (grant_a !== 8'h20 || sel_a !== 3'd5) $display("FAIL drop_owner: grant=%h sel=%0d, want 20/5", grant_a, sel_a);
    else passes++;
    req_a = 8'h40;
    tick();
    checks++;
    if (valid_a !== 1'b0 || timeout_a !== 1'b0 || grant_a !== 8'h00)
      $display("FAIL drop_release: valid=%b to=%b grant=%h, want 0/0/00", valid_a, timeout_a, grant_a);
    else passes++;
    tick();
    checks++;
    if (valid_a !== 1'b1 || sel_a !== 3'd6 || grant_a !== 8'h40)
      $display("FAIL drop_next: valid=%b sel=%0d grant=%h, want 1/6/40", valid_a, sel_a, grant_a);
    else passes++;
  endtask

  task automatic test_masked_req();
    int bad = 0;
    do_reset();
    req_b = 8'hE0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid_b !== 1'b0 || grant_b !== 8'h00) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL masked_req: cycles with grant=%0d, want 0", bad);
    else passes++;
    req_b = '0;
  endtask

  task automatic test_no_timeout();
    int bad = 0;
    do_reset();
    req_b = 8'h04;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (valid_b !== 1'b1 || timeout_b !== 1'b0 || sel_b !== 3'd2 || grant_b !== 8'h04) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL hold_unbounded: bad cycles=%0d, want 0", bad);
    else passes++;
    done_b = 1'b1;
    tick();
    done_b = 1'b0;
    checks++;
    if (valid_b !== 1'b0 || timeout_b !== 1'b0) $display("FAIL hold_done: valid=%b to=%b, want 0/0", valid_b, timeout_b);
    else passes++;
    tick();
    checks++;
    if (valid_b !== 1'b1 || sel_b !== 3'd2) $display("FAIL hold_regrant: valid=%b sel=%0d, want 1/2", valid_b, sel_b);
    else passes++;
    req_b = '0;
  endtask

`ifdef MUX8_ARBITER_LOCK_EN
  task automatic test_lock();
    int bad = 0;
    do_reset();
    req_a = 8'h02; lock_a = 1'b1;
    tick();
    for (int c = 0; c < 10; c++) begin
      tick();
      if (valid_a !== 1'b1 || timeout_a !== 1'b0 || sel_a !== 3'd1) bad++;
    end
    checks++;
    if (bad != 0) $display("FAIL lock_hold: bad cycles=%0d, want 0", bad);
    else passes++;
    lock_a = 1'b0;
    tick();
    checks++;
    if (valid_a !== 1'b0 || timeout_a !== 1'b1) $display("FAIL lock_drop: valid=%b to=%b, want 0/1", valid_a, timeout_a);
    else passes++;
    lock_a = 1'b1;
    tick();
    tick();
    done_a = 1'b1;
    tick();
    done_a = 1'b0;
    checks++;
    if (valid_a !== 1'b0 || timeout_a !== 1'b0) $display("FAIL lock_done: valid=%b to=%b, want 0/0", valid_a, timeout_a);
    else passes++;
    lock_a = 1'b0; req_a = '0;
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if ($urandom_range(0, 3) == 0) req_a = 8'($urandom);
      if ($urandom_range(0, 3) == 0) req_b = 8'($urandom);
      done_a = ($urandom_range(0, 4) == 0);
      done_b = ($urandom_range(0, 4) == 0);
`ifdef MUX8_ARBITER_LOCK_EN
      if ($urandom_range(0, 5) == 0) lock_a = ~lock_a;
`endif
      rst_n = ($urandom_range(0, 99) != 0);
      tick();
      checks++;
      if ({grant_a, sel_a, valid_a, timeout_a} !== exp_vec(0))
        $display("FAIL rand_a cyc %0d: got %h want %h", cyc, {grant_a, sel_a, valid_a, timeout_a}, exp_vec(0));
      else passes++;
      checks++;
      if ({grant_b, sel_b, valid_b, timeout_b} !== exp_vec(1))
        $display("FAIL rand_b cyc %0d: got %h want %h", cyc, {grant_b, sel_b, valid_b, timeout_b}, exp_vec(1));
      else passes++;
      checks++;
      if (!(grant_b == 8'h00 || $onehot(grant_b)) || (valid_b && int'(sel_b) >= B_N))
        $display("FAIL rand_b_onehot cyc %0d: grant=%h sel=%0d", cyc, grant_b, sel_b);
      else passes++;
    end
    rst_n = 1'b1; req_a = '0; req_b = '0; done_a = 1'b0; done_b = 1'b0; lock_a = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_round_robin();
    test_timeout();
    test_req_drop();
    test_masked_req();
    test_no_timeout();
`ifdef MUX8_ARBITER_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
